// File: rtl/spi_adc_scan_ctrl_if.sv
// spi_adc_scan_ctrl_if: scan request, SPI/spi_pts pins and sample result bundle
interface spi_adc_scan_ctrl_if #(parameter int DATA_BITS = 12);
  logic                 start;
  logic [7:0]           chan_mask;
  logic                 miso;
  logic                 sclk;
  logic                 cs_n;
  logic [5:0]           chansel;
  logic                 chan_en;
  logic                 pts_en;
  logic [DATA_BITS-1:0] sample_data;
  logic [2:0]           sample_chan;
  logic                 sample_valid;
  logic                 busy;
  logic                 scan_done;
  modport master (
    input  start, chan_mask, miso,
    output sclk, cs_n, chansel, chan_en, pts_en,
    output sample_data, sample_chan, sample_valid, busy, scan_done
  );
  modport slave (
    output start, chan_mask, miso,
    input  sclk, cs_n, chansel, chan_en, pts_en,
    input  sample_data, sample_chan, sample_valid, busy, scan_done
  );
endinterface

// File: rtl/spi_adc_scan_ctrl.sv
// spi_adc_scan_ctrl: scans masked ADC channels over SPI, one frame per channel, driving spi_pts
module spi_adc_scan_ctrl #(
  parameter int CLK_DIV    = 2,
  parameter int DATA_BITS  = 12,
  parameter int GAP_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  spi_adc_scan_ctrl_if.master adc
);
  localparam int FRAME_LEN = 8 + DATA_BITS;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(FRAME_LEN);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, FRAME, GAP, DONE} state_t;
  state_t               state_q;
  logic [DW-1:0]        div_q;
  logic [PW-1:0]        per_q;
  logic [GW-1:0]        gap_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] sample_data_q;
  logic [7:0]           mask_q;
  logic [2:0]           chan_q;
  logic [2:0]           sample_chan_q;
  logic [5:0]           chansel_q;
  logic                 sclk_q;
  logic                 cs_n_q;
  logic                 chan_en_q;
  logic                 pts_en_q;
  logic                 sample_valid_q;
  logic                 busy_q;
  logic                 scan_done_q;
  logic [7:0]           rem_mask;
  logic [2:0]           next_chan;
  logic [2:0]           first_chan;
  logic [DATA_BITS-1:0] cap_d;
  logic                 div_end;
  function automatic logic [2:0] low_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction
  function automatic logic [5:0] cmd(input logic [2:0] c);
    return {2'b11, c, 1'b0};
  endfunction
  // channels strictly above the current one that are still to be converted
  assign rem_mask   = mask_q & ~((8'd2 << chan_q) - 8'd1);
  assign next_chan  = low_bit(rem_mask);
  assign first_chan = low_bit(adc.chan_mask);
  assign cap_d      = {shift_q[DATA_BITS-2:0], adc.miso};
  assign div_end    = div_q == DW'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      div_q          <= '0;
      per_q          <= '0;
      gap_q          <= '0;
      shift_q        <= '0;
      mask_q         <= '0;
      chan_q         <= '0;
      sclk_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      chansel_q      <= '0;
      chan_en_q      <= 1'b0;
      pts_en_q       <= 1'b0;
      sample_data_q  <= '0;
      sample_chan_q  <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      scan_done_q    <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
      case (state_q)
        IDLE: if (adc.start) begin
          mask_q <= adc.chan_mask;
          busy_q <= 1'b1;
          if (|adc.chan_mask) begin
            state_q   <= SETUP;
            cs_n_q    <= 1'b0;
            chan_q    <= first_chan;
            chansel_q <= cmd(first_chan);
          end else begin
            state_q     <= DONE;
            scan_done_q <= 1'b1;
          end
        end
        SETUP: begin
          div_q <= div_end ? '0 : div_q + DW'(1);
          if (div_end) state_q <= FRAME;
        end
        FRAME: if (!div_end) begin
          div_q <= div_q + DW'(1);
        end else begin
          div_q  <= '0;
          sclk_q <= !sclk_q;
          // enables move only with the rising sclk so spi_pts sees them stable on its falling edge
          if (!sclk_q) begin
            chan_en_q <= per_q == '0;
            pts_en_q  <= per_q >= PW'(1) && per_q <= PW'(6);
          end else if (per_q == PW'(FRAME_LEN - 1)) begin
            state_q        <= GAP;
            cs_n_q         <= 1'b1;
            sample_data_q  <= cap_d;
            sample_chan_q  <= chan_q;
            sample_valid_q <= 1'b1;
            per_q          <= '0;
            shift_q        <= '0;
          end else begin
            per_q <= per_q + PW'(1);
            if (per_q >= PW'(8)) shift_q <= cap_d;
          end
        end
        GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_q <= '0;
          if (|rem_mask) begin
            state_q   <= SETUP;
            cs_n_q    <= 1'b0;
            chan_q    <= next_chan;
            chansel_q <= cmd(next_chan);
          end else begin
            state_q     <= DONE;
            scan_done_q <= 1'b1;
          end
        end else begin
          gap_q <= gap_q + GW'(1);
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign adc.sclk         = sclk_q;
  assign adc.cs_n         = cs_n_q;
  assign adc.chansel      = chansel_q;
  assign adc.chan_en      = chan_en_q;
  assign adc.pts_en       = pts_en_q;
  assign adc.sample_data  = sample_data_q;
  assign adc.sample_chan  = sample_chan_q;
  assign adc.sample_valid = sample_valid_q;
  assign adc.busy         = busy_q;
  assign adc.scan_done    = scan_done_q;
endmodule

// File: tb/tb_spi_adc_scan_ctrl.sv
// tb_spi_adc_scan_ctrl: directed checks of three controllers (CLK_DIV 2, 1, 5) with ADC and spi_pts models
module tb_spi_adc_scan_ctrl;
  logic       clk;
  logic       rst;
  logic       clr;
  logic [2:0] start_v;
  logic [7:0] mask_a [3];
  logic [2:0] done_v;
  logic [11:0] word0;
  int n_cmp;
  int n_err;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  for (genvar g = 0; g < 3; g++) begin : u
    spi_adc_scan_ctrl_if #(.DATA_BITS(12)) bus ();
    spi_adc_scan_ctrl #(.CLK_DIV(g == 0 ? 2 : g == 1 ? 1 : 5), .DATA_BITS(12), .GAP_CYCLES(4)) dut (
      .clk(clk),
      .rst(rst),
      .adc(bus)
    );
    logic        miso = 1'b0;
    logic        p_sclk = 1'b0, p_cs = 1'b1, p_ce = 1'b0, p_pe = 1'b0, p_busy = 1'b0;
    logic [5:0]  pts = '0;
    logic [5:0]  dout_bits = '0;
    logic [11:0] adc_word = '0;
    logic [11:0] exp_log [8];
    logic [11:0] data_log [8];
    logic [5:0]  sel_log [8];
    logic [2:0]  chan_log [8];
    int          frame_rises [8];
    int frames = 0, valids = 0, dones = 0, at_done = 0, gap_cnt = 0, last_gap = 0;
    int edge_viol = 0, cs_low = 0, busy_rise = 0, busy_fall = 0, rise_cnt = 0;
    assign bus.start     = start_v[g];
    assign bus.chan_mask = mask_a[g];
    assign bus.miso      = miso;
    assign done_v[g]     = bus.scan_done;
    always @(negedge clk) begin
      if (clr) begin
        frames = 0; valids = 0; dones = 0; at_done = 0; gap_cnt = 0; last_gap = 0;
        edge_viol = 0; cs_low = 0; busy_rise = 0; busy_fall = 0; rise_cnt = 0;
        miso = 1'b0; pts = '0; dout_bits = '0;
      end else begin
        if (!bus.cs_n) cs_low++;
        if (!bus.cs_n && p_cs) begin
          adc_word = g == 0 ? word0 : 12'($urandom);
          exp_log[frames % 8] = adc_word;
          sel_log[frames % 8] = bus.chansel;
          rise_cnt = 0;
          last_gap = gap_cnt;
        end
        if (bus.cs_n && !p_cs) begin
          frame_rises[frames % 8] = rise_cnt;
          frames++;
          gap_cnt = 0;
        end
        if (bus.cs_n) gap_cnt++;
        if (bus.sclk && !p_sclk && !bus.cs_n) begin
          if (rise_cnt >= 1 && rise_cnt <= 6) dout_bits = {dout_bits[4:0], pts[5]};
          if (rise_cnt >= 8 && rise_cnt < 20) miso = adc_word[19 - rise_cnt];
          rise_cnt++;
        end
        if (!bus.sclk && p_sclk) begin
          if (bus.chan_en) pts = bus.chansel;
          else if (bus.pts_en) pts = {pts[4:0], 1'b0};
          if (bus.chan_en != p_ce || bus.pts_en != p_pe) edge_viol++;
        end
        if (bus.sample_valid) begin
          chan_log[valids % 8] = bus.sample_chan;
          data_log[valids % 8] = bus.sample_data;
          valids++;
        end
        if (bus.scan_done) begin
          dones++;
          at_done = valids;
        end
        if (bus.busy && !p_busy) busy_rise++;
        if (!bus.busy && p_busy) busy_fall++;
      end
      p_sclk = bus.sclk; p_cs = bus.cs_n; p_ce = bus.chan_en; p_pe = bus.pts_en; p_busy = bus.busy;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask
  task automatic start_scan(input int k, input logic [7:0] m);
    @(posedge clk); #1 start_v[k] = 1'b1; mask_a[k] = m;
    @(posedge clk); #1 start_v[k] = 1'b0;
  endtask
  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (!done_v[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_v[k]), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask
  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; clr = 1'b0; start_v = '0; word0 = 12'hA5C;
    for (int k = 0; k < 3; k++) mask_a[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(u[0].bus.cs_n), 1);
    check("rst_sclk", 32'(u[0].bus.sclk), 0);
    check("rst_busy", 32'(u[0].bus.busy), 0);
    check("rst_chansel", 32'(u[0].bus.chansel), 0);
    check("rst_data", 32'(u[0].bus.sample_data), 0);
    rst = 1'b0;
    clear();
    start_scan(0, 8'h04);
    check("t2_busy", 32'(u[0].bus.busy), 1);
    check("t2_cs_low", 32'(u[0].bus.cs_n), 0);
    check("t2_chansel", 32'(u[0].bus.chansel), 32'b110100);
    wait_done(0, 3000);
    check("t2_rises", 32'(u[0].frame_rises[0]), 20);
    check("t2_dout", 32'(u[0].dout_bits), 32'b110100);
    check("t2_valids", 32'(u[0].valids), 1);
    check("t2_data", 32'(u[0].data_log[0]), 32'hA5C);
    check("t2_chan", 32'(u[0].chan_log[0]), 2);
    check("t2_done_after", 32'(u[0].at_done), 1);
    check("t2_edge", 32'(u[0].edge_viol), 0);
    clear();
    start_scan(0, 8'h81);
    wait_done(0, 3000);
    check("t3_frames", 32'(u[0].frames), 2);
    check("t3_chan0", 32'(u[0].chan_log[0]), 0);
    check("t3_chan1", 32'(u[0].chan_log[1]), 7);
    check("t3_sel1", 32'(u[0].sel_log[1]), 32'b111110);
    check("t3_gap", 32'(u[0].last_gap), 4);
    check("t3_data1", 32'(u[0].data_log[1]), 32'hA5C);
    check("t3_done_after", 32'(u[0].at_done), 2);
    clear();
    start_scan(0, 8'h00);
    check("t4_done", 32'(u[0].bus.scan_done), 1);
    check("t4_busy", 32'(u[0].bus.busy), 1);
    @(posedge clk); #1;
    check("t4_done_off", 32'(u[0].bus.scan_done), 0);
    check("t4_busy_off", 32'(u[0].bus.busy), 0);
    repeat (20) @(posedge clk);
    #1;
    check("t4_cs_low", 32'(u[0].cs_low), 0);
    check("t4_valids", 32'(u[0].valids), 0);
    clear();
    start_scan(0, 8'h03);
    repeat (30) @(posedge clk);
    start_scan(0, 8'hFF);
    wait_done(0, 3000);
    check("t5_frames", 32'(u[0].frames), 2);
    check("t5_chan1", 32'(u[0].chan_log[1]), 1);
    check("t5_busy_rise", 32'(u[0].busy_rise), 1);
    check("t5_busy_fall", 32'(u[0].busy_fall), 1);
    check("t5_dones", 32'(u[0].dones), 1);
    clear();
    start_scan(0, 8'h01);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t1_cs_n", 32'(u[0].bus.cs_n), 1);
    check("t1_sclk", 32'(u[0].bus.sclk), 0);
    check("t1_busy", 32'(u[0].bus.busy), 0);
    check("t1_strobes", 32'({u[0].bus.sample_valid, u[0].bus.scan_done}), 0);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("t1_valids", 32'(u[0].valids), 0);
    check("t1_dones", 32'(u[0].dones), 0);
    clear();
    @(posedge clk); #1 start_v = 3'b110; mask_a[1] = 8'hFF; mask_a[2] = 8'hFF;
    @(posedge clk); #1 start_v = 3'b000;
    wait_done(2, 4000);
    check("t6_d1_valids", 32'(u[1].valids), 8);
    check("t6_d5_valids", 32'(u[2].valids), 8);
    check("t6_d1_dones", 32'(u[1].dones), 1);
    check("t6_d1_edge", 32'(u[1].edge_viol), 0);
    check("t6_d5_edge", 32'(u[2].edge_viol), 0);
    for (int f = 0; f < 8; f++) begin
      check("t6_d1_data", 32'(u[1].data_log[f]), 32'(u[1].exp_log[f]));
      check("t6_d5_data", 32'(u[2].data_log[f]), 32'(u[2].exp_log[f]));
      check("t6_d5_chan", 32'(u[2].chan_log[f]), 32'(f));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
